// File: rtl/mem_access_stage.sv
// Load/store stage in front of a word-addressed synchronous data memory.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: misaligned/size-11 requests return an error.
module mem_access_stage #(
  parameter int bits  = 32,
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             reqvalid,
  output logic             reqready,
  input  logic             reqwrite,
  input  logic [1:0]       reqsize,
  input  logic             requnsigned,
  input  logic [bits-1:0]  reqaddress,
  input  logic [width-1:0] reqwdata,
  output logic             respvalid,
  output logic [width-1:0] respdata,
  output logic             resperror,
  output logic             memwriteenable,
  output logic             memreadenable,
  output logic [bits-1:0]  memaddress,
  output logic [width-1:0] memdatain,
  input  logic [width-1:0] memdataout
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_t;

  typedef struct packed {
    logic             write;
    logic             uns;
    logic [1:0]       size;
    logic [1:0]       off;
    logic [width-1:0] wdata;
  } req_t;

  state_t state;
  req_t   rq;

  logic             accept;
  logic             trap;
  logic [1:0]       sz;
  logic [7:0]       lbyte;
  logic [15:0]      lhalf;
  logic [width-1:0] ldval;
  logic [width-1:0] mrg;

  assign accept = reqvalid && (state == IDLE);
  assign sz     = (reqsize == 2'b11) ? 2'b10 : reqsize;

  assign reqready       = (state == IDLE);
  assign respvalid      = (state == RESP);
  assign memreadenable  = (state == RD);
  assign memwriteenable = (state == WR);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misalign;

  always_comb begin
    misalign = 1'b0;
    unique case (1'b1)
      reqsize == 2'b00: misalign = 1'b0;
      reqsize == 2'b01: misalign = reqaddress[0];
      reqsize[1]:       misalign = (reqaddress[1:0] != 2'b00);
      default:          misalign = 1'b0;
    endcase
  end

  assign trap = misalign || (reqsize == 2'b11);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resperror <= 1'b0;
    end else if (accept) begin
      resperror <= trap;
    end else if (state == RESP) begin
      resperror <= 1'b0;
    end
  end
`else
  assign trap      = 1'b0;
  assign resperror = 1'b0;
`endif

  // Lane extraction and extension of the word returned by memory
  always_comb begin
    lbyte = memdataout[{rq.off, 3'b000} +: 8];
    lhalf = rq.off[1] ? memdataout[31:16] : memdataout[15:0];
    ldval = memdataout;
    unique case (1'b1)
      rq.size == 2'b00:
        ldval = {{24{~rq.uns & lbyte[7]}}, lbyte};
      rq.size == 2'b01:
        ldval = {{16{~rq.uns & lhalf[15]}}, lhalf};
      rq.size[1]:
        ldval = memdataout;
      default:
        ldval = memdataout;
    endcase
  end

  // Read-modify-write merge for sub-word stores
  always_comb begin
    mrg = memdataout;
    unique case (1'b1)
      rq.size == 2'b00:
        mrg[{rq.off, 3'b000} +: 8] = rq.wdata[7:0];
      rq.size == 2'b01:
        if (rq.off[1]) begin
          mrg[31:16] = rq.wdata[15:0];
        end else begin
          mrg[15:0] = rq.wdata[15:0];
        end
      rq.size[1]:
        mrg = rq.wdata;
      default:
        mrg = memdataout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      rq         <= '0;
      memaddress <= '0;
      memdatain  <= '0;
      respdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rq.write   <= reqwrite;
            rq.uns     <= requnsigned;
            rq.size    <= sz;
            rq.off     <= reqaddress[1:0];
            rq.wdata   <= reqwdata;
            memaddress <= {2'b00, reqaddress[bits-1:2]};
            respdata   <= '0;
            if (trap) begin
              state <= RESP;
            end else if (reqwrite && sz == 2'b10) begin
              memdatain <= reqwdata;
              state     <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          if (rq.write) begin
            memdatain <= mrg;
            state     <= WR;
          end else begin
            respdata <= ldval;
            state    <= RESP;
          end
        end
        WR: begin
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: byte-level shadow memory model,
// directed cases followed by randomized load/store traffic.
module tb_mem_access_stage;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        reqvalid;
  logic        reqready;
  logic        reqwrite;
  logic [1:0]  reqsize;
  logic        requnsigned;
  logic [31:0] reqaddress;
  logic [31:0] reqwdata;
  logic        respvalid;
  logic [31:0] respdata;
  logic        resperror;
  logic        memwriteenable;
  logic        memreadenable;
  logic [31:0] memaddress;
  logic [31:0] memdatain;
  logic [31:0] memdataout;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sh [256];
  logic [31:0] mem [64];
  logic        pl_we;
  logic [5:0]  pl_a;
  logic [31:0] pl_d;

  logic [31:0] last_data;
  logic        last_err;
  int          last_lat;

  mem_access_stage #(.bits(32), .width(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .reqvalid       (reqvalid),
    .reqready       (reqready),
    .reqwrite       (reqwrite),
    .reqsize        (reqsize),
    .requnsigned    (requnsigned),
    .reqaddress     (reqaddress),
    .reqwdata       (reqwdata),
    .respvalid      (respvalid),
    .respdata       (respdata),
    .resperror      (resperror),
    .memwriteenable (memwriteenable),
    .memreadenable  (memreadenable),
    .memaddress     (memaddress),
    .memdatain      (memdatain),
    .memdataout     (memdataout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else if (memwriteenable) mem[memaddress[5:0]] <= memdatain;
    if (memreadenable) memdataout <= mem[memaddress[5:0]];
  end

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_err(input logic [1:0] s, input int a);
    if (!TRAP) return 1'b0;
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1) return (a % 2) != 0;
    if (s == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int base_of(input logic [1:0] s, input int a);
    return a - (a % nbytes(s));
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s,
                                             input bit u, input int a);
    int n;
    int b;
    logic [31:0] v;
    n = nbytes(s);
    b = base_of(s, a);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(sh[b + i]) << (8 * i));
    if (!u && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] shadow_word(input int w);
    return {sh[4 * w + 3], sh[4 * w + 2], sh[4 * w + 1], sh[4 * w]};
  endfunction

  task automatic do_req(input bit w, input logic [1:0] s, input bit u,
                        input int a, input logic [31:0] d,
                        input string tag);
    bit          err;
    int          n;
    int          explat;
    logic [31:0] expdata;
    logic [31:0] expword;
    bit          rd_seen;
    bit          wr_seen;
    bit          both;
    bit          addr_bad;
    logic [31:0] wd_seen;
    err     = is_err(s, a);
    n       = nbytes(s);
    explat  = err ? 1 : (!w ? 3 : (n == 4 ? 2 : 4));
    expdata = (err || w) ? 32'h0 : model_load(s, u, a);
    expword = 32'h0;
    if (w && !err) begin
      for (int i = 0; i < n; i++)
        sh[base_of(s, a) + i] = d[8 * i +: 8];
      expword = shadow_word(a / 4);
    end
    @(negedge clk);
    chk32({tag, "_ready"}, 32'(reqready), 32'd1);
    reqvalid    = 1'b1;
    reqwrite    = w;
    reqsize     = s;
    requnsigned = u;
    reqaddress  = 32'(a);
    reqwdata    = d;
    @(posedge clk);
    last_lat = 0;
    rd_seen  = 0;
    wr_seen  = 0;
    both     = 0;
    addr_bad = 0;
    wd_seen  = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) reqvalid = 1'b0;
      if (memaddress !== 32'(a / 4)) addr_bad = 1;
      if (memreadenable && memwriteenable) both = 1;
      if (memreadenable) rd_seen = 1;
      if (memwriteenable) begin
        wr_seen = 1;
        wd_seen = memdatain;
      end
      if (respvalid) begin
        last_lat  = c;
        last_data = respdata;
        last_err  = resperror;
        break;
      end
    end
    chk32({tag, "_lat"}, 32'(last_lat), 32'(explat));
    chk32({tag, "_data"}, last_data, expdata);
    chk32({tag, "_err"}, 32'(last_err), 32'(err));
    chk32({tag, "_rden"}, 32'(rd_seen), 32'(!err && (!w || n < 4)));
    chk32({tag, "_wren"}, 32'(wr_seen), 32'(!err && w));
    chk32({tag, "_both"}, 32'(both), 32'd0);
    chk32({tag, "_addr"}, 32'(addr_bad), 32'd0);
    if (w && !err) chk32({tag, "_wdata"}, wd_seen, expword);
  endtask

  initial begin
    logic [31:0] ea;
    logic [31:0] eb;
    int          na;
    int          nb;
    bit          rdy_bad;
    bit          sec_acc;
    bit          pulse;
    logic [31:0] da;
    logic [31:0] db;

    resetn      = 1'b0;
    reqvalid    = 1'b0;
    reqwrite    = 1'b0;
    reqsize     = 2'b00;
    requnsigned = 1'b0;
    reqaddress  = 32'h0;
    reqwdata    = 32'h0;
    pl_we       = 1'b0;
    pl_a        = 6'd0;
    pl_d        = 32'h0;
    last_data   = 32'h0;
    last_err    = 1'b0;
    last_lat    = 0;

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_we = 1'b1;
      pl_a  = 6'(i);
      pl_d  = $urandom;
      for (int k = 0; k < 4; k++) sh[4 * i + k] = pl_d[8 * k +: 8];
    end
    @(negedge clk);
    pl_we = 1'b0;
    @(negedge clk);
    chk32("rst_ready", 32'(reqready), 32'd1);
    chk32("rst_respvalid", 32'(respvalid), 32'd0);
    chk32("rst_respdata", respdata, 32'h0);
    chk32("rst_resperror", 32'(resperror), 32'd0);
    chk32("rst_memaddress", memaddress, 32'h0);
    chk32("rst_memdatain", memdatain, 32'h0);
    chk32("rst_rden", 32'(memreadenable), 32'd0);
    chk32("rst_wren", 32'(memwriteenable), 32'd0);
    resetn = 1'b1;

    do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, "t1_wstore");
    do_req(1, 2'b00, 0, 32'h11, 32'h0000007F, "t2_bstore");
    chk32("t2_mem", mem[4], 32'hDEAD7FEF);
    do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, "t3_restore");
    do_req(0, 2'b00, 0, 32'h13, 32'h0, "t3_lb");
    chk32("t3_lb_const", last_data, 32'hFFFFFFDE);
    do_req(0, 2'b00, 1, 32'h13, 32'h0, "t3_lbu");
    chk32("t3_lbu_const", last_data, 32'h000000DE);
    do_req(0, 2'b01, 0, 32'h12, 32'h0, "t3_lh");
    chk32("t3_lh_const", last_data, 32'hFFFFDEAD);
    do_req(0, 2'b10, 0, 32'h10, 32'h0, "t3_lw");
    chk32("t3_lw_const", last_data, 32'hDEADBEEF);
    do_req(0, 2'b10, 0, 32'h12, 32'h0, "t4_misal");
    chk32("t4_err_const", 32'(last_err), 32'(TRAP));

    // Reset while the load sits in the read state
    @(negedge clk);
    reqvalid    = 1'b1;
    reqwrite    = 1'b0;
    reqsize     = 2'b10;
    requnsigned = 1'b0;
    reqaddress  = 32'h10;
    @(posedge clk);
    @(negedge clk);
    chk32("t5_rd", 32'(memreadenable), 32'd1);
    reqvalid = 1'b0;
    resetn   = 1'b0;
    @(negedge clk);
    chk32("t5_ready", 32'(reqready), 32'd1);
    chk32("t5_outs", {respvalid, resperror, memreadenable,
          memwriteenable}, 32'h0);
    chk32("t5_addr", memaddress, 32'h0);
    chk32("t5_din", memdatain, 32'h0);
    chk32("t5_rdata", respdata, 32'h0);
    resetn = 1'b1;
    pulse  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (respvalid) pulse = 1;
    end
    chk32("t5_nopulse", 32'(pulse), 32'd0);

    // Two loads with reqvalid held high throughout
    ea = model_load(2'b00, 0, 32'h13);
    eb = model_load(2'b01, 1, 32'h26);
    na = 0;
    nb = 0;
    da = 32'h0;
    db = 32'h0;
    rdy_bad = 0;
    sec_acc = 0;
    @(negedge clk);
    reqvalid    = 1'b1;
    reqwrite    = 1'b0;
    reqsize     = 2'b00;
    requnsigned = 1'b0;
    reqaddress  = 32'h13;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        reqsize     = 2'b01;
        requnsigned = 1'b1;
        reqaddress  = 32'h26;
      end
      if (sec_acc) reqvalid = 1'b0;
      if (c <= 3 && reqready) rdy_bad = 1;
      if (c >= 2 && reqready && reqvalid) sec_acc = 1;
      if (respvalid && na == 0) begin
        na = c;
        da = respdata;
      end else if (respvalid) begin
        nb = c;
        db = respdata;
      end
    end
    chk32("t6_rdylow", 32'(rdy_bad), 32'd0);
    chk32("t6_lat_a", 32'(na), 32'd3);
    chk32("t6_lat_b", 32'(nb), 32'd7);
    chk32("t6_data_a", da, ea);
    chk32("t6_data_b", db, eb);

    for (int t = 0; t < 60; t++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             int'($urandom_range(0, 255)), $urandom, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
